// File: rtl/mmu_tlb_if.sv
//==============================================================================
// Module      : mmu_tlb_if
// Description : Request/response, TLB write and TLB probe bundle for mmu_tlb.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mmu_tlb_if #(
  parameter int IDX_W  = 3,
  parameter int ASID_W = 8
);
  logic              req_valid;
  logic [31:0]       req_vaddr;
  logic              req_store;
  logic              req_ready;
  logic [ASID_W-1:0] cp0_asid;

  logic              resp_valid;
  logic [31:0]       resp_paddr;
  logic              resp_uncached;
  logic [1:0]        resp_exc;

  logic              tlbw_en;
  logic [IDX_W-1:0]  tlbw_index;
  logic [31:0]       tlbw_entryhi;
  logic [31:0]       tlbw_lo0;
  logic [31:0]       tlbw_lo1;

  logic              tlbp_en;
  logic [31:0]       tlbp_entryhi;
  logic              tlbp_done;
  logic              tlbp_hit;
  logic [IDX_W-1:0]  tlbp_index;

  modport master (
    output req_valid, req_vaddr, req_store, cp0_asid,
    output tlbw_en, tlbw_index, tlbw_entryhi, tlbw_lo0, tlbw_lo1,
    output tlbp_en, tlbp_entryhi,
    input  req_ready, resp_valid, resp_paddr, resp_uncached, resp_exc,
    input  tlbp_done, tlbp_hit, tlbp_index
  );

  modport slave (
    input  req_valid, req_vaddr, req_store, cp0_asid,
    input  tlbw_en, tlbw_index, tlbw_entryhi, tlbw_lo0, tlbw_lo1,
    input  tlbp_en, tlbp_entryhi,
    output req_ready, resp_valid, resp_paddr, resp_uncached, resp_exc,
    output tlbp_done, tlbp_hit, tlbp_index
  );
endinterface

`default_nettype wire

// File: rtl/mmu_tlb.sv
//==============================================================================
// Module      : mmu_tlb
// Description : Segment decoder plus fully-associative software-loaded joint TLB.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mmu_tlb #(
  parameter int TLB_ENTRIES = 8,
  parameter int IDX_W       = $clog2(TLB_ENTRIES),
  parameter int ASID_W      = 8,
  parameter int MAP_KUSEG   = 1,
  parameter int MAP_KSEG23  = 1
) (
  input  wire logic   clk,
  input  wire logic   rst,
  mmu_tlb_if.slave    bus
);
  localparam logic c_map_kuseg  = (MAP_KUSEG != 0);
  localparam logic c_map_kseg23 = (MAP_KSEG23 != 0);

  logic [18:0]       r_vpn2 [TLB_ENTRIES];
  logic [ASID_W-1:0] r_asid [TLB_ENTRIES];
  logic              r_g    [TLB_ENTRIES];
  logic [19:0]       r_pfn0 [TLB_ENTRIES];
  logic [19:0]       r_pfn1 [TLB_ENTRIES];
  logic [2:0]        r_c0   [TLB_ENTRIES];
  logic [2:0]        r_c1   [TLB_ENTRIES];
  logic              r_d0   [TLB_ENTRIES];
  logic              r_d1   [TLB_ENTRIES];
  logic              r_v0   [TLB_ENTRIES];
  logic              r_v1   [TLB_ENTRIES];

  logic [TLB_ENTRIES-1:0] w_req_match;
  logic [TLB_ENTRIES-1:0] w_prb_match;
  logic                   w_req_hit;
  logic                   w_prb_hit;
  logic [IDX_W-1:0]       w_req_idx;
  logic [IDX_W-1:0]       w_prb_idx;

  logic        w_accept;
  logic        w_use_tlb;
  logic [2:0]  w_seg;
  logic [19:0] w_pfn;
  logic [2:0]  w_c;
  logic        w_d;
  logic        w_v;
  logic [31:0] w_paddr;
  logic        w_uncached;
  logic [1:0]  w_exc;
  logic        w_unused;

  assign w_unused = ^{bus.tlbw_entryhi[12:ASID_W], bus.tlbw_lo0[31:26],
                      bus.tlbw_lo1[31:26], bus.tlbp_entryhi[12:ASID_W]};

  assign w_accept      = bus.req_valid & ~bus.tlbw_en;
  assign bus.req_ready = ~bus.tlbw_en;

  generate
    for (genvar gi = 0; gi < TLB_ENTRIES; gi++) begin : g_match
      assign w_req_match[gi] = (r_vpn2[gi] == bus.req_vaddr[31:13]) &&
                               (r_g[gi] || (r_asid[gi] == bus.cp0_asid));
      assign w_prb_match[gi] = (r_vpn2[gi] == bus.tlbp_entryhi[31:13]) &&
                               (r_g[gi] || (r_asid[gi] == bus.tlbp_entryhi[ASID_W-1:0]));
    end
  endgenerate

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    w_req_hit = 1'b0;
    w_req_idx = '0;
    w_prb_hit = 1'b0;
    w_prb_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (w_req_match[i]) begin
        w_req_hit = 1'b1;
        w_req_idx = IDX_W'(i);
      end
      if (w_prb_match[i]) begin
        w_prb_hit = 1'b1;
        w_prb_idx = IDX_W'(i);
      end
    end
  end

  assign w_seg     = bus.req_vaddr[31:29];
  assign w_use_tlb = (~w_seg[2] & c_map_kuseg) | ((w_seg[2:1] == 2'b11) & c_map_kseg23);

  always_comb begin
    w_pfn = bus.req_vaddr[12] ? r_pfn1[w_req_idx] : r_pfn0[w_req_idx];
    w_c   = bus.req_vaddr[12] ? r_c1[w_req_idx]   : r_c0[w_req_idx];
    w_d   = bus.req_vaddr[12] ? r_d1[w_req_idx]   : r_d0[w_req_idx];
    w_v   = bus.req_vaddr[12] ? r_v1[w_req_idx]   : r_v0[w_req_idx];

    w_paddr    = bus.req_vaddr;
    w_uncached = 1'b0;
    w_exc      = 2'b00;
    if (w_seg == 3'b100) begin
      w_paddr = {3'b000, bus.req_vaddr[28:0]};
    end else if (w_seg == 3'b101) begin
      w_paddr    = {3'b000, bus.req_vaddr[28:0]};
      w_uncached = 1'b1;
    end else if (w_use_tlb) begin
      w_paddr = 32'h0;
      if (!w_req_hit) begin
        w_exc = 2'b01;
      end else if (!w_v) begin
        w_exc = 2'b10;
      end else if (bus.req_store && !w_d) begin
        w_exc = 2'b11;
      end else begin
        w_paddr    = {w_pfn, bus.req_vaddr[11:0]};
        w_uncached = (w_c == 3'b010);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        r_vpn2[i] <= '0;
        r_asid[i] <= '0;
        r_g[i]    <= 1'b0;
        r_pfn0[i] <= '0;
        r_pfn1[i] <= '0;
        r_c0[i]   <= '0;
        r_c1[i]   <= '0;
        r_d0[i]   <= 1'b0;
        r_d1[i]   <= 1'b0;
        r_v0[i]   <= 1'b0;
        r_v1[i]   <= 1'b0;
      end
      bus.resp_valid    <= 1'b0;
      bus.resp_paddr    <= '0;
      bus.resp_uncached <= 1'b0;
      bus.resp_exc      <= 2'b00;
      bus.tlbp_done     <= 1'b0;
      bus.tlbp_hit      <= 1'b0;
      bus.tlbp_index    <= '0;
    end else begin
      bus.resp_valid <= w_accept;
      if (w_accept) begin
        bus.resp_paddr    <= w_paddr;
        bus.resp_uncached <= w_uncached;
        bus.resp_exc      <= w_exc;
      end
      bus.tlbp_done <= bus.tlbp_en;
      if (bus.tlbp_en) begin
        bus.tlbp_hit   <= w_prb_hit;
        bus.tlbp_index <= w_prb_idx;
      end
      // Probe logic above reads the pre-write contents in the same cycle.
      if (bus.tlbw_en) begin
        r_vpn2[bus.tlbw_index] <= bus.tlbw_entryhi[31:13];
        r_asid[bus.tlbw_index] <= bus.tlbw_entryhi[ASID_W-1:0];
        r_g[bus.tlbw_index]    <= bus.tlbw_lo0[0] & bus.tlbw_lo1[0];
        r_pfn0[bus.tlbw_index] <= bus.tlbw_lo0[25:6];
        r_pfn1[bus.tlbw_index] <= bus.tlbw_lo1[25:6];
        r_c0[bus.tlbw_index]   <= bus.tlbw_lo0[5:3];
        r_c1[bus.tlbw_index]   <= bus.tlbw_lo1[5:3];
        r_d0[bus.tlbw_index]   <= bus.tlbw_lo0[2];
        r_d1[bus.tlbw_index]   <= bus.tlbw_lo1[2];
        r_v0[bus.tlbw_index]   <= bus.tlbw_lo0[1];
        r_v1[bus.tlbw_index]   <= bus.tlbw_lo1[1];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mmu_tlb.md
Name: mmu_tlb

Overview:
- Parametrised successor to the MEM-stage fixed-mapping address translator.
- Translates data/instruction virtual addresses to physical addresses:
  - kseg0/kseg1: fixed unmapped windows.
  - kuseg and kseg2/3: a fully-associative, software-loaded, MIPS32-style joint TLB.
- Registered one-cycle lookup with a valid handshake, TLB write port (TLBWI/TLBWR) and probe port (TLBP) driven by CP0.
- Raises TLB exception codes for the exception unit.

Parameters:
- TLB_ENTRIES, 8: number of TLB entries; power of two, 2..32.
- IDX_W, $clog2(TLB_ENTRIES): index width.
- ASID_W, 8: ASID width.
- MAP_KUSEG, 1: 1 = kuseg through TLB; 0 = kuseg identity-mapped (bring-up mode, no TLB exceptions).
- MAP_KSEG23, 1: 1 = kseg2/3 through TLB; 0 = identity-mapped.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  translation request
- req_vaddr  in  32  virtual address
- req_store  in  1  request is a store (dirty check)
- req_ready  out  1  request accepted this cycle when req_valid&req_ready
- cp0_asid  in  ASID_W  current ASID (EntryHi[ASID_W-1:0])
- resp_valid  out  1  response valid
- resp_paddr  out  32  physical address
- resp_uncached  out  1  access is uncached
- resp_exc  out  2  00 none, 01 TLB refill, 10 TLB invalid, 11 TLB modified
- tlbw_en  in  1  write entry
- tlbw_index  in  IDX_W  entry to write
- tlbw_entryhi  in  32  VPN2[31:13], ASID[ASID_W-1:0]
- tlbw_lo0  in  32  PFN[25:6], C[5:3], D[2], V[1], G[0] (even page)
- tlbw_lo1  in  32  same format (odd page)
- tlbp_en  in  1  probe request
- tlbp_entryhi  in  32  probe key
- tlbp_done  out  1  probe result valid
- tlbp_hit  out  1  probe matched
- tlbp_index  out  IDX_W  matched index (0 on miss)

Behaviour:
- Reset (rst=1 at posedge):
  - All entries cleared: V0=V1=D0=D1=G=0, VPN2=0, ASID=0.
  - resp_valid=0, resp_paddr=0, resp_uncached=0, resp_exc=00.
  - tlbp_done=0, tlbp_hit=0, tlbp_index=0.
  - In-flight request or probe is dropped; no response is issued after reset.
- req_ready = ~tlbw_en (combinational); all other cycles ready.
- Latency: accepted request at cycle N gives resp_valid=1 at N+1 for exactly one cycle; back-to-back requests give back-to-back responses.
  - resp_* registers hold their last value while resp_valid=0.
- Segment decode on vaddr[31:29]:
  - 100 (kseg0): paddr={3'b000,vaddr[28:0]}, uncached=0, exc=00.
  - 101 (kseg1): same paddr, uncached=1, exc=00.
  - 0xx (kuseg) with MAP_KUSEG=1, or 11x (kseg2/3) with MAP_KSEG23=1: TLB lookup.
  - Otherwise: paddr=vaddr, uncached=0, exc=00.
- TLB match:
  - Entry i matches when VPN2_i==vaddr[31:13] and (G_i or ASID_i==cp0_asid).
  - Page select = vaddr[12]: 0 uses {PFN0,C0,D0,V0}, 1 uses {PFN1,C1,D1,V1}.
  - Multiple matches: lowest index wins (deterministic).
  - Result:
    - No match: exc=01.
    - Match with V=0: exc=10.
    - Match, V=1, req_store=1, D=0: exc=11.
    - Otherwise exc=00.
  - paddr={PFN[19:0],vaddr[11:0]}.
  - uncached = (C==3'b010).
  - On exc!=00: resp_paddr=0, resp_uncached=0.
- TLB write:
  - On tlbw_en, entry[tlbw_index] is loaded at the clock edge:
    - VPN2=hi[31:13], ASID=hi[ASID_W-1:0].
    - G=lo0[0]&lo1[0].
    - PFN0/1=lo[25:6], C=lo[5:3], D=lo[2], V=lo[1].
  - A request accepted on the cycle after a write sees the new contents.
  - tlbw_index is used as-is; it is always in range by construction.
- TLB probe:
  - tlbp_en at cycle N gives tlbp_done=1 at N+1 for one cycle, with hit/index.
  - Match rule as above, using tlbp_entryhi ASID in place of cp0_asid.
  - Probe ignores page select and V bits.
  - Probe concurrent with tlbw_en compares against pre-write contents.
  - Probe and translation requests are independent and may occur in the same cycle.
- The lookup compare runs combinationally on the request cycle; its result is registered into resp_*. No multi-cycle search.

Test Plan:
- Reset, then req kseg0 0x8000_1234 and kseg1 0xA000_1234 -> next cycles paddr 0x0000_1234 both, uncached 0 then 1, exc 00.
- Empty TLB, req 0x0040_0000 -> resp_exc=01; write idx 3 hi=0x0040_0005, lo0=PFN 0x1F000 V=1 D=1 C=3, asid=5, req 0x0040_0ABC -> paddr 0x1F00_0ABC, exc 00, uncached 0.
- Same entry with lo1 V=0, req 0x0040_1000 -> exc=10; lo0 D=0, store to 0x0040_0000 -> exc=11, load -> exc 00.
- ASID mismatch (cp0_asid=6, G=0) -> exc 01; rewrite with G=1 in both lo -> hit.
- tlbw_en with req_valid the same cycle -> req_ready=0, no resp next cycle; tlbp on written key same cycle as its write -> hit=0; next cycle probe -> hit=1, index=3.
- MAP_KUSEG=0 build: req 0x0040_0000 -> paddr 0x0040_0000, exc 00. Assert rst while a request is in flight -> resp_valid stays 0 and all entries are invalid afterwards.
